// File: rtl/reg_file_32x32.sv
// 32-entry register file written through a one-hot select vector.
// Two registered read ports with write-through bypass, and a sticky
// flag that latches any write request whose select is not one-hot.
module reg_file_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_enable,
    input  logic [31:0]           write_select,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [4:0]            read_addr_a,
    input  logic [4:0]            read_addr_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    output logic                  onehot_error
);

    localparam bit HARD_ZERO = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] regs [32];
    logic [5:0]            select_count;
    logic                  select_onehot;
    logic                  write_valid;
    logic                  bypass_a;
    logic                  bypass_b;
    logic [DATA_WIDTH-1:0] read_next_a;
    logic [DATA_WIDTH-1:0] read_next_b;

    // Population count of the write select; exactly one bit means a legal write.
    always_comb begin
        select_count = '0;
        for (int i = 0; i < 32; i++) begin
            select_count = select_count + {5'd0, write_select[i]};
        end
    end

    assign select_onehot = (select_count == 6'd1);
    assign write_valid   = write_enable && select_onehot;

    // Write-through: a discarded register-0 write must not leak onto a read port.
    always_comb begin
        bypass_a = write_valid && write_select[read_addr_a]
                   && !(HARD_ZERO && (read_addr_a == 5'd0));
        bypass_b = write_valid && write_select[read_addr_b]
                   && !(HARD_ZERO && (read_addr_b == 5'd0));
        read_next_a = bypass_a ? write_data : regs[read_addr_a];
        read_next_b = bypass_b ? write_data : regs[read_addr_b];
    end

    // Storage array: per-register load enable; register 0 stays zero when hardwired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (write_valid && write_select[i] && !(HARD_ZERO && (i == 0))) begin
                    regs[i] <= write_data;
                end
            end
        end
    end

    // Registered read outputs, updated every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_a <= '0;
            read_data_b <= '0;
        end else begin
            read_data_a <= read_next_a;
            read_data_b <= read_next_b;
        end
    end

    // Sticky malformed-select flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_error <= 1'b0;
        end else if (write_enable && !select_onehot) begin
            onehot_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Bench for reg_file_32x32: two instances (register 0 hardwired and not)
// share one stimulus stream and are checked every cycle against an
// array-based model, plus literal expectations from directed vectors.
module tb_reg_file_32x32;

    logic        clk;
    logic        rst_n;
    logic        write_enable;
    logic [31:0] write_select;
    logic [31:0] write_data;
    logic [4:0]  read_addr_a;
    logic [4:0]  read_addr_b;
    logic [31:0] rda_z, rdb_z, rda_n, rdb_n;
    logic        err_z, err_n;

    int tests_run = 0;
    int tests_failed = 0;
    bit chk_en = 0;

    reg_file_32x32 #(.DATA_WIDTH(32), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .write_enable(write_enable),
        .write_select(write_select), .write_data(write_data),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(rda_z), .read_data_b(rdb_z), .onehot_error(err_z));

    reg_file_32x32 #(.DATA_WIDTH(32), .ZERO_REG(0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .write_enable(write_enable),
        .write_select(write_select), .write_data(write_data),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(rda_n), .read_data_b(rdb_n), .onehot_error(err_n));

    initial clk = 0;
    always #5 clk = ~clk;

    // Model state: contents as seen by software, expected outputs.
    logic [31:0] mem_z [32];
    logic [31:0] mem_n [32];
    logic [31:0] exp_a_z, exp_b_z, exp_a_n, exp_b_n;
    logic        exp_err;

    // Model: apply the write (if legal), then the read ports see the updated contents.
    always @(posedge clk or negedge rst_n) begin
        int ones;
        int idx;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem_z[i] = 0;
                mem_n[i] = 0;
            end
            exp_a_z = 0; exp_b_z = 0; exp_a_n = 0; exp_b_n = 0;
            exp_err = 0;
        end else begin
            ones = 0;
            idx = 0;
            for (int i = 0; i < 32; i++) begin
                if (write_select[i]) begin
                    ones = ones + 1;
                    idx = i;
                end
            end
            if (write_enable && ones != 1) exp_err = 1;
            if (write_enable && ones == 1) begin
                mem_n[idx] = write_data;
                if (idx != 0) mem_z[idx] = write_data;
            end
            exp_a_z = mem_z[read_addr_a];
            exp_b_z = mem_z[read_addr_b];
            exp_a_n = mem_n[read_addr_a];
            exp_b_n = mem_n[read_addr_b];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rda_z", rda_z, exp_a_z);
            check("model_rdb_z", rdb_z, exp_b_z);
            check("model_rda_n", rda_n, exp_a_n);
            check("model_rdb_n", rdb_n, exp_b_n);
            check("model_err_z", {31'd0, err_z}, {31'd0, exp_err});
            check("model_err_n", {31'd0, err_n}, {31'd0, exp_err});
        end
    end

    // Drive one cycle of stimulus just after an edge; returns just after the next edge.
    task automatic cyc(input logic we, input logic [31:0] ws, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
        write_enable = we;
        write_select = ws;
        write_data   = wd;
        read_addr_a  = ra;
        read_addr_b  = rb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        write_enable = 0;
        write_select = 0;
        write_data = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        write_enable = 0; write_select = 0; write_data = 0;
        read_addr_a = 0; read_addr_b = 0;
        @(posedge clk); #1;
        check("reset_rda", rda_z, 32'h0);
        check("reset_err", {31'd0, err_z}, 32'h0);
        do_reset();
        chk_en = 1;

        // 1: load, reset mid-run, read back zeros
        cyc(1, 32'h0000_0020, 32'h5555_AAAA, 5'd0, 5'd0);
        cyc(1, 32'h8000_0000, 32'h7777_1111, 5'd5, 5'd31);
        cyc(0, 32'h0, 32'h0, 5'd5, 5'd31);
        check("pre_reset_rda", rda_z, 32'h5555_AAAA);
        do_reset();
        cyc(0, 32'h0, 32'h0, 5'd5, 5'd31);
        check("post_reset_rda", rda_z, 32'h0);
        check("post_reset_rdb", rdb_z, 32'h0);
        check("post_reset_err", {31'd0, err_z}, 32'h0);

        // 2: basic write/read and full sweep
        cyc(1, 32'h0000_0400, 32'hDEAD_BEEF, 5'd0, 5'd0);
        cyc(0, 32'h0, 32'h0, 5'd10, 5'd0);
        check("basic_rda", rda_z, 32'hDEAD_BEEF);
        for (int i = 0; i < 32; i++)
            cyc(1, 32'h1 << i, 32'h1000_0000 + i, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++)
            cyc(0, 32'h0, 32'h0, i[4:0], 5'(31 - i));
        check("sweep_last_rda_n", rda_n, 32'h1000_001F);
        check("sweep_last_rdb_z", rdb_z, 32'h0);

        // 3: bypass on both ports
        cyc(1, 32'h0000_0080, 32'hCAFE_F00D, 5'd7, 5'd7);
        check("bypass_rda", rda_z, 32'hCAFE_F00D);
        check("bypass_rdb", rdb_z, 32'hCAFE_F00D);

        // 4: register 0 write
        cyc(1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0);
        check("zero_bypass_z", rda_z, 32'h0);
        check("zero_bypass_n", rda_n, 32'hFFFF_FFFF);
        cyc(0, 32'h0, 32'h0, 5'd0, 5'd0);
        check("zero_hold_z", rdb_z, 32'h0);
        check("zero_hold_n", rdb_n, 32'hFFFF_FFFF);
        check("zero_err", {31'd0, err_z}, 32'h0);

        // 5: malformed selects
        do_reset();
        cyc(0, 32'hFFFF_FFFF, 32'h1234_5678, 5'd0, 5'd1);
        check("we0_no_err", {31'd0, err_z}, 32'h0);
        cyc(1, 32'h0000_0002, 32'h0BAD_F00D, 5'd0, 5'd1);
        cyc(1, 32'h0000_0003, 32'h1234_5678, 5'd0, 5'd1);
        check("bad_no_bypass", rdb_z, 32'h0BAD_F00D);
        check("bad_err", {31'd0, err_z}, 32'h1);
        for (int i = 0; i < 10; i++)
            cyc(1, 32'h1 << (i + 4), 32'hA000_0000 + i, 5'd0, 5'd1);
        check("bad_sticky", {31'd0, err_n}, 32'h1);
        check("bad_reg1_kept", rdb_n, 32'h0BAD_F00D);
        do_reset();
        cyc(1, 32'h0, 32'h1111_1111, 5'd0, 5'd0);
        check("zero_sel_err", {31'd0, err_z}, 32'h1);

        // 6: async reset between edges with a write pending
        do_reset();
        cyc(1, 32'h0000_0100, 32'h2468_ACE0, 5'd8, 5'd8);
        check("pre_async_rda", rda_z, 32'h2468_ACE0);
        write_enable = 1; write_select = 32'h0000_0008; write_data = 32'h1357_9BDF;
        read_addr_a = 5'd8; read_addr_b = 5'd3;
        #2;
        rst_n = 0;
        #1;
        check("async_rda", rda_z, 32'h0);
        check("async_rda_n", rda_n, 32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        cyc(0, 32'h0, 32'h0, 5'd3, 5'd3);
        check("async_reg3", rda_z, 32'h0);
        check("async_err", {31'd0, err_z}, 32'h0);

        cyc(0, 32'h0, 32'h0, 5'd0, 5'd0);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
